// File: rtl/fifo_pack_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pack_pkg;

  typedef enum logic {FILL, HOLD} state_t;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_RATIO = 4;

  // Lane index width; never narrower than one bit.
  function automatic int laneWidth(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  // Entries wider than 64 bits would need a wider argument here.
  function automatic logic evenParity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries and packs RATIO of them into one valid/ready beat.
// Optional per-lane parity output enabled by FIFO_PACK_PARITY_EN.
module fifo_rd_packer
  import fifo_pack_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int RATIO = DEF_RATIO
)(
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic [DSIZE-1:0]       rdata,
  input  logic                   rempty,
  output logic                   rinc,
  input  logic                   flush,
  output logic [DSIZE*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_keep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
`ifdef FIFO_PACK_PARITY_EN
  ,
  output logic [RATIO-1:0]       out_par
`endif
);

  localparam int OWIDTH = DSIZE * RATIO;
  localparam int CW = laneWidth(RATIO);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  assign rinc = rrst_n && (state == FILL) && !rempty;
  assign busy = (cnt != '0) || out_valid;

  // The capture lane is decoded against cnt so every slice index stays constant.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= FILL;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
`ifdef FIFO_PACK_PARITY_EN
      out_par   <= '0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (rinc) begin
            for (int k = 0; k < RATIO; k++) begin
              if (cnt == CW'(k)) begin
                out_data[DSIZE*k +: DSIZE] <= rdata;
                out_keep[k]                <= 1'b1;
`ifdef FIFO_PACK_PARITY_EN
                out_par[k]                 <= evenParity(64'(rdata));
`endif
              end
            end
            cnt <= cnt + 1'b1;
          end
          // cnt is parked at zero while a beat is held; busy is carried by out_valid.
          if ((rinc && cnt == LAST) || (flush && (rinc || cnt != '0))) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            cnt       <= '0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            cnt       <= '0;
`ifdef FIFO_PACK_PARITY_EN
            out_par   <= '0;
`endif
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  logic unusedWidth;
  assign unusedWidth = ^OWIDTH;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: FIFO model, reference packer model, monitor.
module tb_fifo_rd_packer;

  localparam int DSIZE = 8;
  localparam int RATIO = 4;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  par;
  } beat_t;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic [7:0]  rdata = '0;
  logic        rempty = 1'b1;
  logic        rinc;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
`ifdef FIFO_PACK_PARITY_EN
  logic [3:0]  out_par;
`endif

  fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .flush(flush), .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
`ifdef FIFO_PACK_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 rclk = ~rclk;

  int total = 0;
  int bad = 0;

  beat_t      sbQ[$];
  logic [7:0] fifoQ[$];
  logic [7:0] modelLanes[$];

  int bubblePct = 0;
  bit readyRandom = 0;
  bit readyLevel = 1;
  bit flushPulse = 0;
  bit flushOnLast = 0;
  bit popNow = 0;
  int validCycles = 0;
  int rincInHold = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference packer: lanes accumulate in order, a beat forms at RATIO lanes or on flush.
  task automatic emitModelBeat();
    beat_t b;
    b.data = '0;
    b.keep = '0;
    b.par  = '0;
    for (int k = 0; k < modelLanes.size(); k++) begin
      b.data = b.data | (32'(modelLanes[k]) << (8 * k));
      b.keep[k] = 1'b1;
      b.par[k]  = ^modelLanes[k];
    end
    sbQ.push_back(b);
    modelLanes.delete();
  endtask

  task automatic modelFlush();
    if (modelLanes.size() > 0) emitModelBeat();
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    fifoQ.push_back(v);
    modelLanes.push_back(v);
    if (modelLanes.size() == RATIO) emitModelBeat();
  endtask

  // FIFO and downstream environment: pops on rinc, drives read port and out_ready.
  initial begin
    bit bubble;
    forever begin
      @(negedge rclk);
      popNow = rinc;
      @(posedge rclk);
      #1;
      if (popNow) begin
        if (fifoQ.size() > 0) void'(fifoQ.pop_front());
        else checkOutput("pop_from_empty", 32'(popNow), 32'd0);
      end
      bubble    = ($urandom_range(99) < bubblePct);
      rempty    = (fifoQ.size() == 0) || bubble;
      rdata     = (fifoQ.size() > 0) ? fifoQ[0] : 8'($urandom);
      out_ready = readyRandom ? 1'($urandom_range(1)) : readyLevel;
      flush     = flushPulse || (flushOnLast && fifoQ.size() == 1 && !rempty);
      if (flush) flushOnLast = 0;
      flushPulse = 0;
    end
  end

  // Monitor: compares each transferred beat against the scoreboard head.
  initial begin
    bit prevHeld = 0;
    logic [31:0] heldData;
    beat_t exp;
    forever begin
      @(negedge rclk);
      if (!rrst_n) begin
        prevHeld = 0;
        continue;
      end
      if (out_valid) validCycles++;
      if (out_valid && rinc) rincInHold++;
      if (prevHeld) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", out_data, heldData);
      end
      prevHeld = out_valid && !out_ready;
      heldData = out_data;
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_beat", out_data, 32'hdeadbeef);
        end else begin
          exp = sbQ.pop_front();
          checkOutput("beat_data", out_data, exp.data);
          checkOutput("beat_keep", 32'(out_keep), 32'(exp.keep));
`ifdef FIFO_PACK_PARITY_EN
          checkOutput("beat_par", 32'(out_par), 32'(exp.par));
`endif
        end
      end
    end
  end

  task automatic waitIdle(input int budget);
    int n = 0;
    while (!(sbQ.size() == 0 && fifoQ.size() == 0 && !busy) && n < budget) begin
      @(negedge rclk);
      n++;
    end
    if (n >= budget) checkOutput("idle_timeout", 32'(sbQ.size()), 32'd0);
  endtask

  task automatic waitFifoEmpty(input int budget);
    int n = 0;
    while (fifoQ.size() != 0 && n < budget) begin
      @(negedge rclk);
      n++;
    end
    if (n >= budget) checkOutput("fifo_timeout", 32'(fifoQ.size()), 32'd0);
    @(negedge rclk);
  endtask

  initial begin
    #1;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_data", out_data, 32'd0);
    checkOutput("reset_keep", 32'(out_keep), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rinc", 32'(rinc), 32'd0);
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;

    // Two full beats with out_ready held high.
    validCycles = 0;
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    waitIdle(100);
    checkOutput("two_beats_valid_cycles", 32'(validCycles), 32'd2);
    checkOutput("two_beats_busy", 32'(busy), 32'd0);

    // Backpressure: beat held, no pops while held.
    readyLevel = 0;
    rincInHold = 0;
    for (int i = 0; i < 5; i++) applyStimulus(8'h21 + 8'(i));
    repeat (16) @(negedge rclk);
    checkOutput("bp_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_data", out_data, 32'h24232221);
    checkOutput("bp_rinc_seen", 32'(rincInHold), 32'd0);
    checkOutput("bp_fifo_left", 32'(fifoQ.size()), 32'd1);
    readyLevel = 1;
    waitFifoEmpty(50);
    modelFlush();
    flushPulse = 1;
    waitIdle(50);

    // Flush of a three-lane partial beat.
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    applyStimulus(8'hA3);
    waitFifoEmpty(50);
    checkOutput("partial_busy", 32'(busy), 32'd1);
    modelFlush();
    flushPulse = 1;
    waitIdle(50);

    // Flush coinciding with the capture of the final lane of a short beat.
    applyStimulus(8'hB1);
    applyStimulus(8'hB2);
    modelFlush();
    flushOnLast = 1;
    waitIdle(50);
    // And with the fourth lane, which completes the beat anyway.
    for (int i = 1; i <= 4; i++) applyStimulus(8'hA0 + 8'(i));
    flushOnLast = 1;
    waitIdle(50);

    // Flush while idle is ignored.
    validCycles = 0;
    flushPulse = 1;
    repeat (5) @(negedge rclk);
    checkOutput("idle_flush_valid", 32'(validCycles), 32'd0);
    checkOutput("idle_flush_busy", 32'(busy), 32'd0);

    // Reset during a fill drops the partial beat.
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    waitFifoEmpty(50);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge rclk);
    #3 rrst_n = 1'b0;
    #1;
    checkOutput("mid_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_reset_data", out_data, 32'd0);
    checkOutput("mid_reset_keep", 32'(out_keep), 32'd0);
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    checkOutput("mid_reset_rinc", 32'(rinc), 32'd0);
    modelLanes.delete();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(8'h11 + 8'(i));
    waitIdle(50);

    // Randomised stream with bubbles and random backpressure.
    applyStimulus(8'h07);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h80);
    bubblePct = 40;
    readyRandom = 1;
    for (int i = 0; i < 256; i++) applyStimulus(8'($urandom));
    waitIdle(5000);
    readyRandom = 0;
    bubblePct = 0;
    repeat (3) @(negedge rclk);
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("end_scoreboard", 32'(sbQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-side consumer for the async FIFO, in the rclk domain. Pops DSIZE-bit entries through the FIFO read port (rdata/rempty/rinc) and packs RATIO consecutive entries into one wide beat. Beats are presented downstream on a valid/ready handshake. A flush input emits a partial beat with a lane-keep mask.

Parameters:
DSIZE, 8, width of one FIFO entry (must match the FIFO DSIZE)
RATIO, 4, entries packed per output beat (>=2)
OWIDTH, DSIZE*RATIO, derived localparam; output beat width (not overridable)

Ports:
rclk  input  1  read-domain clock; all state updates on posedge
rrst_n  input  1  asynchronous active-low reset
rdata  input  DSIZE  FIFO read data; valid whenever rempty=0
rempty  input  1  FIFO empty flag (already synchronised in rclk domain)
rinc  output  1  pop strobe to FIFO; one entry consumed per rclk cycle it is high
flush  input  1  request to emit the current partial beat
out_data  output  OWIDTH  packed beat; entry k in bits [DSIZE*k +: DSIZE], entry 0 = first popped
out_keep  output  RATIO  lane-valid mask for out_data
out_valid  output  1  beat available
out_ready  input  1  downstream accepts beat
busy  output  1  high when a partial or held beat exists

Behaviour:
- Reset (async assert, sync release): state=FILL, cnt=0, out_valid=0, out_data=0, out_keep=0, busy=0. rinc is forced to 0 while rrst_n=0. A reset mid-operation discards the partial beat and the held beat with no output.
- States: FILL and HOLD.
- FILL:
  - rinc = !rempty (combinational).
  - On each edge with rinc=1: rdata is written to lane cnt, out_keep[cnt] is set, and cnt increments.
  - If the captured entry is in lane RATIO-1, go to HOLD with out_valid=1 at that same edge.
  - Latency: out_valid rises on the edge that captures the last entry.
- Flush in FILL:
  - If flush=1 and (cnt>0 or an entry is captured this cycle), go to HOLD with out_valid=1.
  - A capture in the same cycle is included before emission.
  - If flush=1 with cnt=0 and no capture, the flush is ignored.
  - Unfilled lanes have data 0 and keep 0.
- HOLD:
  - rinc=0.
  - out_data, out_keep and out_valid stay stable until out_valid && out_ready.
  - On handshake: next state is FILL, cnt=0, out_keep=0, out_data=0, out_valid=0.
  - flush is ignored in HOLD (not remembered).
- out_ready may be high before out_valid. A beat transfers only on an edge where both are high.
- busy = (cnt!=0) || out_valid.
- cnt width is $clog2(RATIO). cnt never exceeds RATIO-1 and never wraps without a state change.
- rempty toggling between pops creates bubbles only: packing order is preserved and no entries are lost or duplicated.
- There is no pop in the handshake cycle. Peak throughput is RATIO entries per RATIO+1 cycles.

Optional Feature:
- Macro: FIFO_PACK_PARITY_EN.
- When defined: adds output port out_par [RATIO-1:0]. out_par[k] is the even parity (XOR reduction) of the entry in lane k. It is computed and registered on the capture edge and is 0 for lanes not kept. It follows the same hold/clear rules as out_data.
- When undefined: the port does not exist and no parity logic is generated.

Decomposition:
- Shared package fifo_pack_pkg contains:
  - the state enum (FILL, HOLD)
  - a function returning the lane-index width for a given RATIO
  - the default DSIZE/RATIO constants
- No sub-module: single module. The parity reduction is an inline function in the package.

Test Plan:
- DSIZE=8, RATIO=4. FIFO holds 0x01..0x08, out_ready=1 → two beats: 0x04030201 then 0x08070605, out_keep=0xF for both, out_valid high one cycle each. FIFO is empty afterwards and busy=0.
- After 4 entries, hold out_ready=0 for 10 cycles → out_valid stays 1, out_data is stable, rinc=0 throughout, and the next FIFO entry is still unread. Raising out_ready causes one transfer and popping resumes the next cycle.
- Pop 0xA1, 0xA2, 0xA3, then pulse flush → out_data=0x00A3A2A1, out_keep=0x7. Flush coinciding with a pop of 0xA4 → out_data=0xA4A3A2A1, out_keep=0xF.
- Flush with cnt=0 and FIFO empty → no out_valid and no state change.
- Pop 2 entries, assert rrst_n=0 mid-fill → all outputs 0 immediately. After release, the next entries 0x11..0x14 form a clean beat 0x14131211.
- Randomly toggle rempty with a 256-entry stream → output beats reproduce the input order exactly. With FIFO_PACK_PARITY_EN, out_par matches per-lane XOR (entry 0x07 gives parity 1).
